// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge: single-outstanding core load/store to AXI4 one-beat read/write bridge
// with per-transaction watchdog; all AXI and core-side outputs are registered.
module axi_lite_master_bridge #(
    parameter logic [3:0]  ID      = 4'd0,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic [3:0]  rid,
    input  logic        rlast,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    output logic [3:0]  awid,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,
    input  logic [3:0]  bid
);
    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, wd_q, wd_d, wd_inc;
    logic [2:0]  size_q, size_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, err_q, err_d;
    logic        arvalid_q, arvalid_d, rready_q, rready_d, awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d, bready_q, bready_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic        busy, expire, unused_resp_lsb;

    assign unused_resp_lsb = rresp[0] ^ bresp[0];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        wd_inc       = wd_q + 32'd1;
        busy         = state_q inside {RD_AR, RD_R, WR_AWW, WR_B};
        expire       = (TIMEOUT != 0) && (wd_inc >= TIMEOUT - 1);
        wd_d         = busy ? wd_inc : wd_q;
        case (state_q)
            IDLE: if (req_valid && req_ready_q) begin
                addr_d      = req_addr;
                size_d      = req_size;
                wdata_d     = req_wdata;
                wstrb_d     = req_wstrb;
                wd_d        = '0;
                req_ready_d = 1'b0;
                aw_done_d   = 1'b0;
                w_done_d    = 1'b0;
                awvalid_d   = req_wen;
                wvalid_d    = req_wen;
                arvalid_d   = !req_wen;
                state_d     = req_wen ? WR_AWW : RD_AR;
            end
            RD_AR: if (arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = RD_R;
            end
            RD_R: if (rvalid) begin
                rready_d     = 1'b0;
                rdata_d      = rdata;
                err_d        = rresp[1] | (rid != ID) | !rlast;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            WR_AWW: begin
                aw_done_d = aw_done_q | (awvalid_q & awready);
                w_done_d  = w_done_q | (wvalid_q & wready);
                awvalid_d = awvalid_q & ~awready;
                wvalid_d  = wvalid_q & ~wready;
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end
            end
            WR_B: if (bvalid) begin
                bready_d     = 1'b0;
                rdata_d      = '0;
                err_d        = bresp[1] | (bid != ID);
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: if (resp_ready) begin
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A response arriving in the expiry cycle still wins over the timeout
        if (busy && expire && state_d != RESP) begin
            arvalid_d    = 1'b0;
            rready_d     = 1'b0;
            awvalid_d    = 1'b0;
            wvalid_d     = 1'b0;
            bready_d     = 1'b0;
            rdata_d      = '0;
            err_d        = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            wd_q         <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            wd_q         <= wd_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign arvalid    = arvalid_q;
    assign araddr     = addr_q;
    assign arid       = ID;
    assign arlen      = 8'd0;
    assign arsize     = size_q;
    assign arburst    = 2'b01;
    assign rready     = rready_q;
    assign awvalid    = awvalid_q;
    assign awaddr     = addr_q;
    assign awid       = ID;
    assign awlen      = 8'd0;
    assign awsize     = size_q;
    assign awburst    = 2'b01;
    assign wvalid     = wvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign wlast      = wvalid_q;
    assign bready     = bready_q;
endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// tb_axi_lite_master_bridge: directed bench with a behavioural AXI slave and a response scoreboard.
module tb_axi_lite_master_bridge;
    localparam logic [3:0]  ID  = 4'd3;
    localparam int unsigned TMO = 16;

    logic        clk = 1'b0, rst = 1'b0;
    logic        req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_size = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready, rlast = 1'b0;
    logic [31:0] araddr, rdata = '0;
    logic [3:0]  arid, rid = '0;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp = '0, bresp = '0;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, wlast, bvalid = 1'b0, bready;
    logic [31:0] awaddr, wdata;
    logic [3:0]  awid, wstrb, bid = '0;

    axi_lite_master_bridge #(.ID(ID), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
        .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
    );

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0, cyc = 0;
    int aw_hi = 0, w_hi = 0, b_hs = 0;
    int ar_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    bit ar_never = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0, s_bresp = '0;
    logic [3:0]  s_rid = ID, s_bid = ID;
    logic        s_rlast = 1'b1;

    always #5 clk = ~clk;

    initial forever @(posedge clk) cyc++;

    // Slave: drives at negedge, a handshake set up at one negedge completes on the next posedge
    initial begin
        int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
        bit ar_fire = 0, r_fire = 0, aw_fire = 0, w_fire = 0, b_fire = 0, aw_got = 0, w_got = 0;
        forever begin
            @(negedge clk);
            if (awvalid) aw_hi++;
            if (wvalid) w_hi++;
            if (!rst) begin
                {arready, rvalid, awready, wready, bvalid} = '0;
                {ar_fire, r_fire, aw_fire, w_fire, b_fire, aw_got, w_got} = '0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else begin
                if (r_fire) rvalid = 1'b0;
                if (b_fire) begin bvalid = 1'b0; b_hs++; end
                if (ar_fire) begin
                    rvalid = 1'b1; rdata = s_rdata; rresp = s_rresp; rid = s_rid; rlast = s_rlast;
                end
                if (aw_fire) aw_got = 1;
                if (w_fire) w_got = 1;
                if (aw_got && w_got) begin
                    if (b_cnt >= b_delay) begin
                        bvalid = 1'b1; bresp = s_bresp; bid = s_bid;
                        aw_got = 0; w_got = 0; b_cnt = 0;
                    end else b_cnt++;
                end
                arready = arvalid && !ar_never && ar_cnt >= ar_delay;
                ar_cnt  = arvalid ? ar_cnt + 1 : 0;
                awready = awvalid && aw_cnt >= aw_delay;
                aw_cnt  = awvalid ? aw_cnt + 1 : 0;
                wready  = wvalid && w_cnt >= w_delay;
                w_cnt   = wvalid ? w_cnt + 1 : 0;
                ar_fire = arvalid && arready;
                r_fire  = rvalid && rready;
                aw_fire = awvalid && awready;
                w_fire  = wvalid && wready;
                b_fire  = bvalid && bready;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic wen, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wd, input logic [3:0] ws,
                          input logic [31:0] er, input logic ee, output int t);
        exp_t e;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
        req_wdata = wd; req_wstrb = ws;
        t = cyc;
        e.rdata = er; e.err = ee;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int t, input int lat, input int hold);
        int n = 0;
        exp_t e;
        logic [31:0] r0;
        logic e0;
        while (!resp_valid && n < 100) begin @(negedge clk); n++; end
        if (!resp_valid) begin
            checks++; errors++;
            $error("FAIL resp_wait: no resp_valid within %0d cycles", n);
            return;
        end
        check("latency", cyc - t, lat);
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL scoreboard: response with nothing expected");
            return;
        end
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", resp_err, e.err);
        r0 = resp_rdata; e0 = resp_err;
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", resp_valid, 1);
            check("hold_rdata", resp_rdata, r0);
            check("hold_err", resp_err, e0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_drop", resp_valid, 0);
        check("req_ready_back", req_ready, 1);
    endtask

    initial begin
        int t, a0, w0, b0, n;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid}, 0);
        check("rst_araddr", araddr, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_wstrb", wstrb, 0);
        check("rst_resp", {resp_err, resp_rdata}, 0);
        rst = 1'b1;

        s_rdata = 32'hDEADBEEF;
        do_req(1'b0, 32'h1000_0006, 3'd2, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, t);
        check("ar_valid", arvalid, 1);
        check("ar_addr", araddr, 32'h1000_0006);
        check("ar_len", arlen, 0);
        check("ar_burst", arburst, 1);
        check("ar_id", arid, ID);
        check("ar_size", arsize, 2);
        check("aw_idle_on_read", awvalid, 0);
        wait_resp(t, 3, 2);

        aw_delay = 2; a0 = aw_hi; w0 = w_hi; b0 = b_hs;
        do_req(1'b1, 32'ha00003f8, 3'd0, 32'h41, 4'b0001, 32'h0, 1'b0, t);
        check("aw_w_valid", {awvalid, wvalid, wlast}, 3'b111);
        check("aw_addr", awaddr, 32'ha00003f8);
        check("w_data", wdata, 32'h41);
        check("w_strb", wstrb, 4'b0001);
        check("aw_len_burst_id", {awlen, awburst, awid}, {8'd0, 2'b01, ID});
        check("aw_size", awsize, 0);
        wait_resp(t, 5, 0);
        check("aw_cycles_slow", aw_hi - a0, 3);
        check("w_cycles_slow", w_hi - w0, 1);
        check("b_count_slow", b_hs - b0, 1);

        aw_delay = 0; b_delay = 1; a0 = aw_hi; w0 = w_hi; b0 = b_hs;
        do_req(1'b1, 32'h2000_0010, 3'd2, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, t);
        wait_resp(t, 4, 0);
        check("aw_cycles_same", aw_hi - a0, 1);
        check("w_cycles_same", w_hi - w0, 1);
        check("b_count_same", b_hs - b0, 1);
        b_delay = 0;

        s_bresp = 2'b10;
        do_req(1'b1, 32'h2000_0014, 3'd1, 32'h0000_BEEF, 4'b0011, 32'h0, 1'b1, t);
        wait_resp(t, 3, 0);
        s_bresp = 2'b00;

        s_rresp = 2'b10; s_rdata = 32'h1234_5678;
        do_req(1'b0, 32'h3000_0000, 3'd2, 32'h0, 4'h0, 32'h1234_5678, 1'b1, t);
        wait_resp(t, 3, 0);
        s_rresp = 2'b00; s_rid = ID + 4'd1; s_rdata = 32'h0BAD_F00D;
        do_req(1'b0, 32'h3000_0004, 3'd2, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b1, t);
        wait_resp(t, 3, 0);
        s_rid = ID; s_rlast = 1'b0; s_rdata = 32'h5A5A_A5A5;
        do_req(1'b0, 32'h3000_0008, 3'd2, 32'h0, 4'h0, 32'h5A5A_A5A5, 1'b1, t);
        wait_resp(t, 3, 0);
        s_rlast = 1'b1;

        ar_never = 1; s_rdata = 32'hFFFF_FFFF;
        do_req(1'b0, 32'h4000_0000, 3'd2, 32'h0, 4'h0, 32'h0, 1'b1, t);
        wait_resp(t, TMO, 0);
        check("ar_low_after_timeout", arvalid, 0);
        ar_never = 0;

        b_delay = 8;
        do_req(1'b1, 32'h5000_0000, 3'd2, 32'h1111_2222, 4'hF, 32'h0, 1'b0, t);
        n = 0;
        while (!bready && n < 20) begin @(negedge clk); n++; end
        if (!bready) begin
            checks++; errors++;
            $error("FAIL wr_b_wait: bready never observed");
        end
        #2 rst = 1'b0;
        #1 check("async_rst_valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid}, 0);
        check("async_rst_req_ready", req_ready, 1);
        sb.delete();
        @(negedge clk);
        #1 rst = 1'b1;
        b_delay = 0;
        repeat (3) @(negedge clk);
        check("no_resp_after_rst", resp_valid, 0);
        check("idle_after_rst", {req_ready, bready}, 2'b10);

        s_rdata = 32'h600D_CAFE;
        do_req(1'b0, 32'h6000_0003, 3'd0, 32'h0, 4'h0, 32'h600D_CAFE, 1'b0, t);
        check("ar_addr_unaligned", araddr, 32'h6000_0003);
        wait_resp(t, 3, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_master_bridge.md
Name: axi_lite_master_bridge

Overview:
- Single-outstanding AXI4 initiator that turns a simple core-side load/store request into one-beat AXI4 read or write bursts.
- Sits between the LSU/IFU and the crossbar.
- Drives the same AXI4 channel set the peripheral slaves (UART, SRAM) respond on, including IDs, len/size/burst and last.
- Returns read data or a write acknowledge, plus an error flag, to the core.

Parameters:
- ID, 4'd0, AXI ID driven on arid/awid and expected back on rid/bid.
- TIMEOUT, 1024, cycles allowed from request acceptance to response handshake; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  bridge idle, can accept
- req_wen  in  1  1=write, 0=read
- req_addr  in  32  byte address
- req_size  in  3  AXI size encoding (0=byte,1=half,2=word)
- req_wdata  in  32  write data, lane-aligned
- req_wstrb  in  4  write strobes
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  read data (0 for writes)
- resp_err  out  1  error flag
- arvalid/arready  out/in  1  AR handshake
- araddr  out  32  read address
- arid  out  4  = ID
- arlen  out  8  = 0
- arsize  out  3  latched req_size
- arburst  out  2  = 2'b01 (INCR)
- rvalid/rready  in/out  1  R handshake
- rdata  in  32  read data
- rresp  in  2  read response
- rid  in  4  read ID
- rlast  in  1  last beat
- awvalid/awready  out/in  1  AW handshake
- awaddr  out  32  write address
- awid  out  4  = ID
- awlen  out  8  = 0
- awsize  out  3  latched req_size
- awburst  out  2  = 2'b01 (INCR)
- wvalid/wready  out/in  1  W handshake
- wdata  out  32  latched write data
- wstrb  out  4  latched strobes
- wlast  out  1  = wvalid
- bvalid/bready  in/out  1  B handshake
- bresp  in  2  write response
- bid  in  4  write ID

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE.
  - All valid/ready outputs 0 except req_ready=1.
  - araddr/awaddr/wdata/wstrb/resp_rdata=0, resp_err=0, watchdog=0.
  - Reset asserted mid-transaction drops all valids immediately; the in-flight transaction is abandoned, with no response to the core.
- States: IDLE, RD_AR, RD_R, WR_AWW, WR_B, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch addr, size, wdata, wstrb, wen; clear watchdog.
  - Go to RD_AR (wen=0) or WR_AWW (wen=1).
  - req_ready=0 in every other state.
- RD_AR:
  - arvalid=1 with stable araddr/arsize until arready.
  - arvalid never deasserts without handshake.
  - On handshake go to RD_R.
- RD_R:
  - rready=1.
  - On rvalid: capture rdata into resp_rdata.
  - err = rresp[1] | (rid!=ID) | !rlast.
  - Go to RESP.
- WR_AWW:
  - awvalid and wvalid both asserted the cycle after acceptance.
  - Each drops independently on its own handshake (aw_done/w_done flags).
  - Same-cycle AW and W handshakes are both recorded.
  - When both done (including the cycle the last one completes), go to WR_B.
  - wlast=1 whenever wvalid=1.
- WR_B:
  - bready=1.
  - On bvalid: err = bresp[1] | (bid!=ID); resp_rdata=0.
  - Go to RESP.
- RESP:
  - resp_valid=1, with resp_rdata/resp_err stable until resp_ready.
  - On handshake go to IDLE; req_ready rises the next cycle, so there is no same-cycle re-accept.
- Latency with an always-ready zero-wait slave:
  - Read: accept cycle T; arvalid at T+1; R handshake at T+2; resp_valid at T+3.
  - Write: awvalid/wvalid at T+1; B handshake at T+2 or later (slave-dependent); resp_valid the cycle after.
- Watchdog (TIMEOUT>0):
  - Counts each cycle in RD_AR/RD_R/WR_AWW/WR_B.
  - When count reaches TIMEOUT-1 without completing, go to RESP with resp_err=1 and resp_rdata=0.
  - Drop all AXI valids/readies.
  - Late AXI responses arriving afterwards are ignored (readies are 0).
- Unaligned addresses are passed through unchanged; the bridge does no alignment checks.

Test Plan:
- Read, zero-wait slave returning rdata=32'hDEADBEEF, rresp=0, rid=ID, rlast=1 -> resp_valid at T+3, resp_rdata=32'hDEADBEEF, resp_err=0; arlen=0, arburst=1.
- Write addr=32'ha00003f8, wdata=32'h41, wstrb=4'b0001, slave with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles, single B handshake, resp_err=0.
- Write where AW and W complete in the same cycle, bvalid 2 cycles later -> one response; awvalid/wvalid each high exactly 1 cycle.
- Read with rresp=2'b10, then read with rid=ID+1 -> resp_err=1 both times; resp_rdata holds the captured rdata.
- TIMEOUT=16, slave never asserts arready -> resp_valid with resp_err=1 exactly 16 cycles after acceptance; arvalid=0 afterwards.
- rst pulsed low while in WR_B; core holds resp_ready=0 through RESP -> all valids 0 immediately and req_ready=1 after release; resp fields stay stable while resp_ready=0.
